// File: rtl/irq_pend_pkg.sv
// Shared types and helpers for the sticky-request MSB-priority dispatcher.
package irq_pend_pkg;

    function automatic int unsigned idx_width(input int unsigned n);
        return $clog2(n);
    endfunction

    typedef enum logic {
        StIdle  = 1'b0,
        StValid = 1'b1
    } state_e;

endpackage

// File: rtl/msb_prio_enc.sv
// Combinational MSB priority encoder: index of the highest set bit, zero when empty.
module msb_prio_enc
    import irq_pend_pkg::*;
#(
    parameter int unsigned N     = 10,
    parameter int unsigned IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     cand_i,
    output logic [IDX_W-1:0] sel_o,
    output logic             any_o
);

    always_comb begin
        sel_o = '0;
        // Ascending scan so the last hit, the MSB, wins.
        for (int i = 0; i < N; i++) begin
            if (cand_i[i]) begin
                sel_o = IDX_W'(i);
            end
        end
    end

    assign any_o = |cand_i;

endmodule

// File: rtl/irq_pend_arb.sv
// Sticky request collector with masked MSB-priority dispatch on a registered valid/ready output.
// Define PEND_OVF_EN to build the sticky lost-request detector behind overflow_o.
module irq_pend_arb
    import irq_pend_pkg::*;
#(
    parameter int unsigned N     = 10,
    parameter int unsigned IDX_W = idx_width(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_i,
    input  logic [N-1:0]     mask_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     pending_o,
    output logic             overflow_o
);

    state_e           state_q;
    logic             out_valid_q;
    logic [IDX_W-1:0] out_idx_q;
    logic [N-1:0]     pending_q, pending_d;
    logic [N-1:0]     cand, clr;
    logic [IDX_W-1:0] sel;
    logic             any, claim;

    assign cand = pending_q & ~mask_i;

    msb_prio_enc #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_enc (
        .cand_i (cand),
        .sel_o  (sel),
        .any_o  (any)
    );

    // A new index is taken when idle, or when the current one is being accepted.
    always_comb begin
        claim     = any && ((state_q == StIdle) || out_ready);
        clr       = claim ? (N'(1) << sel) : '0;
        pending_d = (pending_q & ~clr) | req_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            pending_q   <= '0;
        end else begin
            pending_q <= pending_d;
            case (state_q)
                StIdle: begin
                    if (any) begin
                        out_idx_q   <= sel;
                        out_valid_q <= 1'b1;
                        state_q     <= StValid;
                    end
                end
                StValid: begin
                    if (out_ready) begin
                        if (any) begin
                            out_idx_q <= sel;
                        end else begin
                            out_valid_q <= 1'b0;
                            state_q     <= StIdle;
                        end
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

`ifdef PEND_OVF_EN
    logic overflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_q | (|(req_i & pending_q & ~clr));
        end
    end

    assign overflow_o = overflow_q;
`else
    assign overflow_o = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign pending_o = pending_q;

endmodule

// File: tb/tb_irq_pend_arb.sv
// Directed bench: expected indices queued at stimulus time, popped on each accepted handshake.
module tb_irq_pend_arb;

    localparam int unsigned N     = 10;
    localparam int unsigned IDX_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_i;
    logic [N-1:0]     mask_i;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic [N-1:0]     pending_o;
    logic             overflow_o;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    logic ovf_exp;

    irq_pend_arb #(
        .N (N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .mask_i     (mask_i),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .pending_o  (pending_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Outputs settle just after the edge; inputs are driven right after that too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake scoreboard: inputs are stable at the falling edge before they are sampled.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("hs_unexpected", 32'(out_idx), 32'hFFFF_FFFF);
            end else begin
                check("hs_idx", 32'(out_idx), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
`ifdef PEND_OVF_EN
        ovf_exp = 1'b1;
`else
        ovf_exp = 1'b0;
`endif
        rst       = 1'b1;
        req_i     = 10'h3FF;
        mask_i    = '0;
        out_ready = 1'b0;
        #1;

        // Reset held two cycles with every request line high
        tick();
        tick();
        rst   = 1'b0;
        req_i = '0;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_idx", 32'(out_idx), 32'd0);
        check("rst_pend", 32'(pending_o), 32'd0);
        check("rst_ovf", 32'(overflow_o), 32'd0);
        tick();
        check("rst_pend_after", 32'(pending_o), 32'd0);

        // Ordering: bits 5 and 2, MSB first, one per cycle
        req_i     = 10'b00_0010_0100;
        out_ready = 1'b1;
        tick();
        req_i = '0;
        check("ord_pend", 32'(pending_o), 32'h024);
        check("ord_valid_t1", 32'(out_valid), 32'd0);
        exp_q.push_back(5);
        exp_q.push_back(2);
        tick();
        check("ord_valid_t2", 32'(out_valid), 32'd1);
        check("ord_idx_t2", 32'(out_idx), 32'd5);
        tick();
        check("ord_idx_t3", 32'(out_idx), 32'd2);
        tick();
        check("ord_valid_t4", 32'(out_valid), 32'd0);
        check("ord_pend_t4", 32'(pending_o), 32'd0);

        // Backpressure hold and re-arm of bit 9
        out_ready = 1'b0;
        req_i     = 10'h200;
        tick();
        req_i = '0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_idx", 32'(out_idx), 32'd9);
            if (i == 2) req_i = 10'h200;
            else req_i = '0;
            tick();
        end
        req_i = '0;
        check("bp_rearm_pend", 32'(pending_o), 32'h200);
        check("bp_no_ovf", 32'(overflow_o), 32'd0);
        exp_q.push_back(9);
        exp_q.push_back(9);
        out_ready = 1'b1;
        tick();
        check("bp_second_valid", 32'(out_valid), 32'd1);
        check("bp_second_idx", 32'(out_idx), 32'd9);
        check("bp_second_pend", 32'(pending_o), 32'd0);
        tick();
        check("bp_idle", 32'(out_valid), 32'd0);

        // Mask bit 9: 8..0 drain in order, 9 stays pending until unmasked
        mask_i = 10'h200;
        req_i  = 10'h3FF;
        for (int k = 8; k >= 0; k--) exp_q.push_back(k);
        tick();
        req_i = '0;
        check("msk_pend", 32'(pending_o), 32'h3FF);
        tick();
        for (int k = 8; k >= 0; k--) begin
            check("msk_idx", 32'(out_idx), 32'(k));
            tick();
        end
        check("msk_idle", 32'(out_valid), 32'd0);
        check("msk_pend_left", 32'(pending_o), 32'h200);
        mask_i = '0;
        exp_q.push_back(9);
        tick();
        check("unmsk_valid", 32'(out_valid), 32'd1);
        check("unmsk_idx", 32'(out_idx), 32'd9);
        tick();
        check("unmsk_idle", 32'(out_valid), 32'd0);

        // Overflow: bit 4 pending behind a held index, then requested again
        out_ready = 1'b0;
        req_i     = 10'h030;
        tick();
        req_i = '0;
        tick();
        check("ovf_idx_held", 32'(out_idx), 32'd5);
        check("ovf_pend4", 32'(pending_o), 32'h010);
        check("ovf_before", 32'(overflow_o), 32'd0);
        req_i = 10'h010;
        tick();
        req_i = '0;
        check("ovf_set", 32'(overflow_o), 32'(ovf_exp));
        tick();
        tick();
        check("ovf_sticky", 32'(overflow_o), 32'(ovf_exp));
        exp_q.push_back(5);
        exp_q.push_back(4);
        out_ready = 1'b1;
        tick();
        check("ovf_drain_idx", 32'(out_idx), 32'd4);
        tick();
        check("ovf_drain_idle", 32'(out_valid), 32'd0);
        check("ovf_still", 32'(overflow_o), 32'(ovf_exp));

        // Mid-operation reset discards the claimed index and pending bits
        out_ready = 1'b0;
        req_i     = 10'h01F;
        tick();
        req_i = '0;
        tick();
        check("mid_valid", 32'(out_valid), 32'd1);
        check("mid_idx", 32'(out_idx), 32'd4);
        check("mid_pend", 32'(pending_o), 32'h00F);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_pend", 32'(pending_o), 32'd0);
        check("mid_rst_idx", 32'(out_idx), 32'd0);
        check("mid_rst_ovf", 32'(overflow_o), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_no_stale", 32'(out_valid), 32'd0);
        end

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
